// File: rtl/cpu_dbg_pkg.sv
// Shared types for the CPU clock/debug controller.
// Holds the controller state encoding and the statistics counter width.
// Imported by cpu_clock_ctrl and its breakpoint comparator.
package cpu_dbg_pkg;

    typedef enum logic [1:0] {
        ST_HALT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STEP_CYC = 2'd2,
        ST_STEP_INS = 2'd3
    } cpu_state_e;

    localparam int CYCLE_CNT_W = 32;

endpackage

// File: rtl/cpu_clock_ctrl_bp_match.sv
// Breakpoint comparator array with lowest-index priority encoder.
// Purely combinational; the caller decides when the result is sampled.
// Only opcode fetches (sync_i) can match.
module bp_match
    import cpu_dbg_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int NUM_BP = 4,
    parameter int IDX_W  = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
    input  logic [ADDR_W-1:0]        addr_i,
    input  logic                     sync_i,
    input  logic [NUM_BP*ADDR_W-1:0] bp_addr_i,
    input  logic [NUM_BP-1:0]        bp_en_i,
    output logic                     any_match_o,
    output logic [IDX_W-1:0]         match_index_o
);

    // Scan from the top entry down so the lowest matching index is the one left standing.
    always_comb begin
        any_match_o   = 1'b0;
        match_index_o = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (bp_en_i[i] && sync_i && (addr_i == bp_addr_i[i*ADDR_W +: ADDR_W])) begin
                any_match_o   = 1'b1;
                match_index_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/cpu_clock_ctrl.sv
// Glitch-free divided PHI2 source with run/halt, cycle step, instruction step and breakpoints.
// PHI2 first rises HALF_PERIOD CLKs after leaving HALT; every decision lands on the PHI2 1->0 edge.
// Halt requests never truncate a phase: the current PHI2 period always completes first.
module cpu_clock_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int ADDR_W          = 16,
    parameter int NUM_BP          = 4,
    parameter int HALF_PERIOD     = 6,
    parameter int MAX_STEP_CYCLES = 16
) (
    input  logic                                         CLK,
    input  logic                                         RESET,
    input  logic                                         RUN,
    input  logic                                         STEP,
    input  logic                                         STEP_MODE,
    input  logic [ADDR_W-1:0]                            A,
    input  logic                                         SYNC,
    input  logic [NUM_BP*ADDR_W-1:0]                     BP_ADDR,
    input  logic [NUM_BP-1:0]                            BP_EN,
    output logic                                         PHI2,
    output logic                                         CYCLE_END,
    output logic                                         HALTED,
    output logic                                         BP_HIT,
    output logic [((NUM_BP > 1) ? $clog2(NUM_BP) : 1)-1:0] BP_INDEX,
    output logic [CYCLE_CNT_W-1:0]                       CYCLE_COUNT
);

    localparam int IDX_W  = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;
    localparam int PH_W   = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int STEP_W = $clog2(MAX_STEP_CYCLES + 1);

    cpu_state_e               state_q;
    logic [PH_W-1:0]          phase_q;
    logic                     phi2_q;
    logic                     cycle_end_q;
    logic                     halted_q;
    logic                     bp_hit_q;
    logic [IDX_W-1:0]         bp_index_q;
    logic [CYCLE_CNT_W-1:0]   cycle_count_q;
    logic [STEP_W-1:0]        step_cnt_q;

    logic                     phase_tc;
    logic                     cycle_end_d;
    logic                     stop_d;
    logic                     any_match;
    logic [IDX_W-1:0]         match_index;

    bp_match #(
        .ADDR_W (ADDR_W),
        .NUM_BP (NUM_BP),
        .IDX_W  (IDX_W)
    ) u_bp_match (
        .addr_i        (A),
        .sync_i        (SYNC),
        .bp_addr_i     (BP_ADDR),
        .bp_en_i       (BP_EN),
        .any_match_o   (any_match),
        .match_index_o (match_index)
    );

    // Last CLK of the high phase: breakpoints, SYNC and RUN are all judged here.
    assign phase_tc    = (phase_q == PH_W'(HALF_PERIOD - 1));
    assign cycle_end_d = (state_q != ST_HALT) && phase_tc && phi2_q;

    // Whether the cycle now ending should be the last one before HALT.
    always_comb begin
        stop_d = 1'b0;
        case (state_q)
            ST_RUN:      stop_d = any_match | ~RUN;
            ST_STEP_CYC: stop_d = 1'b1;
            ST_STEP_INS: stop_d = any_match
                                | ((step_cnt_q != '0) & SYNC)
                                | (step_cnt_q == STEP_W'(MAX_STEP_CYCLES - 1));
            default:     stop_d = 1'b0;
        endcase
    end

    // Controller FSM, phase divider and cycle statistics with registered outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= ST_HALT;
            phase_q       <= '0;
            phi2_q        <= 1'b0;
            cycle_end_q   <= 1'b0;
            halted_q      <= 1'b1;
            bp_hit_q      <= 1'b0;
            bp_index_q    <= '0;
            cycle_count_q <= '0;
            step_cnt_q    <= '0;
        end else begin
            cycle_end_q <= 1'b0;
            case (state_q)
                ST_HALT: begin
                    phase_q <= '0;
                    phi2_q  <= 1'b0;
                    // RUN has priority over a simultaneous STEP.
                    if (RUN) begin
                        state_q  <= ST_RUN;
                        halted_q <= 1'b0;
                        bp_hit_q <= 1'b0;
                    end else if (STEP) begin
                        state_q    <= STEP_MODE ? ST_STEP_INS : ST_STEP_CYC;
                        halted_q   <= 1'b0;
                        bp_hit_q   <= 1'b0;
                        step_cnt_q <= '0;
                    end
                end
                default: begin
                    if (phase_tc) begin
                        phase_q <= '0;
                        phi2_q  <= ~phi2_q;
                    end else begin
                        phase_q <= phase_q + PH_W'(1);
                    end
                    if (cycle_end_d) begin
                        cycle_end_q   <= 1'b1;
                        cycle_count_q <= cycle_count_q + CYCLE_CNT_W'(1);
                        step_cnt_q    <= step_cnt_q + STEP_W'(1);
                        if (any_match) begin
                            bp_hit_q   <= 1'b1;
                            bp_index_q <= match_index;
                        end
                        if (stop_d) begin
                            state_q  <= ST_HALT;
                            halted_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign PHI2        = phi2_q;
    assign CYCLE_END   = cycle_end_q;
    assign HALTED      = halted_q;
    assign BP_HIT      = bp_hit_q;
    assign BP_INDEX    = bp_index_q;
    assign CYCLE_COUNT = cycle_count_q;

endmodule

// File: doc/cpu_clock_ctrl.md
Name: cpu_clock_ctrl

Overview:
Next-generation CPU clock controller for the 6502 core, replacing the key-mux PHI2 source with a glitch-free, divided, stoppable PHI2.
- Adds run/halt, single-cycle step, single-instruction step and NUM_BP hardware address breakpoints.
- Sits between the debounced front-panel keys and the CPU/IO clock inputs, clocked from the 48 MHz board clock.

Parameters:
ADDR_W, 16, CPU address width compared by breakpoints
NUM_BP, 4, number of breakpoint comparators (>=1)
HALF_PERIOD, 6, CLK cycles per PHI2 phase (48 MHz / 12 = 4 MHz); >=1
MAX_STEP_CYCLES, 16, instruction-step watchdog limit in CPU cycles

Ports:
CLK  in  1  board clock; all logic on posedge
RESET  in  1  synchronous, active-high
RUN  in  1  level; 1 requests free-run
STEP  in  1  one-CLK pulse (debounced and edge-detected upstream)
STEP_MODE  in  1  0 = cycle step, 1 = instruction step; sampled with STEP
A  in  ADDR_W  CPU address bus
SYNC  in  1  CPU opcode-fetch flag
BP_ADDR  in  NUM_BP*ADDR_W  breakpoint addresses; entry i at [i*ADDR_W +: ADDR_W]
BP_EN  in  NUM_BP  per-breakpoint enable
PHI2  out  1  registered CPU clock
CYCLE_END  out  1  one-CLK pulse marking the PHI2 1->0 edge
HALTED  out  1  1 while stopped
BP_HIT  out  1  sticky breakpoint-halt flag
BP_INDEX  out  max(1,$clog2(NUM_BP))  index of the breakpoint that halted
CYCLE_COUNT  out  32  CPU cycles completed since reset

Behaviour:
- Reset values: PHI2=0, CYCLE_END=0, HALTED=1, BP_HIT=0, BP_INDEX=0, CYCLE_COUNT=0, phase counter=0, state=HALT.
- RESET mid-cycle forces all of the above on the next edge. A truncated PHI2 high phase is acceptable because CPU reset is asserted concurrently.
- PHI2 generation:
  - Phase counter runs 0..HALF_PERIOD-1 only when state != HALT.
  - At terminal count, PHI2 toggles; each phase is exactly HALF_PERIOD CLKs.
  - A cycle starts with the low phase. PHI2 first rises HALF_PERIOD CLKs after the state leaves HALT.
  - In HALT, PHI2 is held 0 and the counter is held 0. No runt pulses ever occur outside RESET.
- CYCLE_END is registered alongside the PHI2 1->0 edge and is high in the first CLK where PHI2 reads 0. CYCLE_COUNT increments on the same edge and wraps at 2^32.
- Match sampling: A, SYNC, BP_ADDR and BP_EN are sampled on the last CLK of the PHI2 high phase. match_i = BP_EN[i] & SYNC & (A == BP_ADDR[i]). Multiple matches report the lowest index.
- States: HALT, RUN, STEP_CYC, STEP_INS. All decisions outside HALT are taken only at a cycle end.
  - HALT:
    - RUN=1 -> RUN.
    - Else STEP=1 -> STEP_CYC (STEP_MODE=0) or STEP_INS (STEP_MODE=1).
    - Leaving HALT clears BP_HIT.
    - RUN and STEP in the same CLK: RUN wins.
    - STEP outside HALT is ignored.
  - RUN: at cycle end, if any match -> HALT with BP_HIT=1 and BP_INDEX set; else if RUN=0 -> HALT. A RUN drop always completes the current cycle.
  - STEP_CYC: exactly one full PHI2 period, then HALT. A match in that cycle still sets BP_HIT and BP_INDEX.
  - STEP_INS:
    - Counts completed cycles. At a cycle end other than the first: SYNC=1 -> HALT (stopped after the next opcode fetch).
    - A match at any cycle end -> HALT with BP_HIT.
    - After MAX_STEP_CYCLES cycles -> HALT (watchdog).
    - RUN rising while stepping: finish the step, halt, then enter RUN next CLK.
- Resume after a breakpoint halt: the first cycle executed is not a fetch, so no immediate re-trigger.
- HALTED is registered and equals (state==HALT).

Decomposition:
- Package cpu_dbg_pkg: state enum (HALT, RUN, STEP_CYC, STEP_INS) and the cycle-count width localparam.
- Sub-module bp_match: NUM_BP comparator array plus lowest-index priority encoder. It is combinational and produces any_match and match_index.
- The FSM, phase counter and statistics stay in cpu_clock_ctrl.

Test Plan:
- Reset, RUN=1 held: PHI2 is low 6 CLKs, high 6, period 12. CYCLE_END pulses every 12 CLKs. CYCLE_COUNT=10 after 120 CLKs. HALTED=0.
- RUN dropped 2 CLKs into a high phase: the phase completes fully (6 CLKs), CYCLE_END fires, then HALTED=1 with PHI2 held 0. No PHI2 pulse is shorter than 6 CLKs.
- Halted, STEP with STEP_MODE=0: exactly one PHI2 pulse, CYCLE_COUNT +1, HALTED=1 again 12 CLKs later. A STEP during the pulse is ignored.
- STEP_MODE=1, bench drives SYNC=1 on cycles 0 and 4: halts after cycle 4 (5 cycles, CYCLE_COUNT +5). With SYNC held 0: halts after 16 cycles.
- RUN with BP_EN=4'b0110, BP_ADDR[1]=BP_ADDR[2]=16'hC000, fetch of C000: halt after that cycle with BP_HIT=1 and BP_INDEX=1. Re-asserting RUN clears BP_HIT and runs on.
- RESET asserted mid high phase: PHI2=0, HALTED=1 and CYCLE_COUNT=0 on the next CLK. RUN and STEP asserted together in HALT: enters RUN.
